// File: rtl/dvp_frame_gen.sv
// dvp_frame_gen: DVP camera-side transmitter emulating OV7670 output timing.
// Produces vsync / href framing and an 8-bit byte stream carrying RGB565
// pixels (high byte first). One frame per start pulse, or back-to-back
// frames while continuous is held high. Three test patterns are available.
module dvp_frame_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 100,
    parameter int VS_FRONT = 10,
    parameter int VS_PULSE = 10,
    parameter int VS_BACK  = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic [1:0] pattern_sel,
    output logic       vsync,
    output logic       href,
    output logic [7:0] dout,
    output logic       busy,
    output logic       frame_done
);

    localparam int LINE_BYTES = 2 * H_ACTIVE;
    localparam int MAX_0      = (VS_FRONT > VS_PULSE) ? VS_FRONT : VS_PULSE;
    localparam int MAX_1      = (MAX_0 > VS_BACK) ? MAX_0 : VS_BACK;
    localparam int MAX_2      = (MAX_1 > H_BLANK) ? MAX_1 : H_BLANK;
    localparam int MAX_LEN    = (MAX_2 > LINE_BYTES) ? MAX_2 : LINE_BYTES;
    localparam int CNT_W      = $clog2(MAX_LEN + 1);
    localparam int X_W_RAW    = $clog2(H_ACTIVE);
    localparam int X_W        = (X_W_RAW < 8) ? 8 : X_W_RAW;
    // y must be able to hold V_ACTIVE itself: it reaches that value once the
    // last line has been emitted and is used to detect end of frame.
    localparam int Y_W_RAW    = $clog2(V_ACTIVE + 1);
    localparam int Y_W        = (Y_W_RAW < 8) ? 8 : Y_W_RAW;
    localparam int BAR_PIX    = H_ACTIVE / 8;
    localparam int BAR_W      = $clog2(BAR_PIX + 1);

    localparam logic [CNT_W-1:0] FRONT_LAST = CNT_W'(VS_FRONT - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(VS_PULSE - 1);
    localparam logic [CNT_W-1:0] BACK_LAST  = CNT_W'(VS_BACK - 1);
    localparam logic [CNT_W-1:0] LINE_LAST  = CNT_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(H_BLANK - 1);
    localparam logic [X_W-1:0]   X_LAST     = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]   Y_END      = Y_W'(V_ACTIVE);
    localparam logic [BAR_W-1:0] BAR_LAST   = BAR_W'(BAR_PIX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VS_PRE,
        S_VS_HIGH,
        S_VS_POST,
        S_LINE,
        S_HBLANK,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       pattern_reg;

    // Position of the *next* byte to be emitted (look-ahead so dout can be
    // registered on the same edge that raises href).
    logic [X_W-1:0]   x_reg;
    logic [Y_W-1:0]   y_reg;
    logic             phase_reg;
    logic [BAR_W-1:0] bar_cnt_reg;
    logic [2:0]       bar_idx_reg;
    logic [7:0]       byte_cnt_reg;

    logic             cnt_last;
    logic             frame_start;
    logic             emit;
    logic [15:0]      pix_word;
    logic [7:0]       pix_byte;

    // Terminal count of the state-duration counter for the current state
    always_comb begin
        cnt_last = 1'b0;
        case (state_reg)
            S_VS_PRE:  cnt_last = (cnt_reg == FRONT_LAST);
            S_VS_HIGH: cnt_last = (cnt_reg == PULSE_LAST);
            S_VS_POST: cnt_last = (cnt_reg == BACK_LAST);
            S_LINE:    cnt_last = (cnt_reg == LINE_LAST);
            S_HBLANK:  cnt_last = (cnt_reg == BLANK_LAST);
            default:   cnt_last = 1'b0;
        endcase
    end

    // A frame begins on an accepted start or on a continuous restart from DONE;
    // emit is high on every edge whose following cycle is a LINE cycle.
    assign frame_start = ((state_reg == S_IDLE) && start) ||
                         ((state_reg == S_DONE) && continuous);
    assign emit = ((state_reg == S_VS_POST) && cnt_last) ||
                  ((state_reg == S_HBLANK) && cnt_last && (y_reg != Y_END)) ||
                  ((state_reg == S_LINE) && !cnt_last);

    // Pixel word for the selected pattern and the byte of it due next
    always_comb begin
        pix_word = 16'h0000;
        case (pattern_reg)
            2'd1: begin
                case (bar_idx_reg)
                    3'd0:    pix_word = 16'hFFFF;
                    3'd1:    pix_word = 16'hFFE0;
                    3'd2:    pix_word = 16'h07FF;
                    3'd3:    pix_word = 16'h07E0;
                    3'd4:    pix_word = 16'hF81F;
                    3'd5:    pix_word = 16'hF800;
                    3'd6:    pix_word = 16'h001F;
                    default: pix_word = 16'h0000;
                endcase
            end
            2'd2:    pix_word = {x_reg[7:3], y_reg[7:2], ~x_reg[7:3]};
            default: pix_word = 16'h0000;
        endcase
        if ((pattern_reg == 2'd1) || (pattern_reg == 2'd2)) begin
            pix_byte = phase_reg ? pix_word[7:0] : pix_word[15:8];
        end else begin
            pix_byte = byte_cnt_reg;
        end
    end

    // Frame timing FSM with registered framing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            pattern_reg <= 2'd0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg   <= S_VS_PRE;
                        cnt_reg     <= '0;
                        pattern_reg <= pattern_sel;
                        busy        <= 1'b1;
                    end
                end
                S_VS_PRE: begin
                    if (cnt_last) begin
                        state_reg <= S_VS_HIGH;
                        cnt_reg   <= '0;
                        vsync     <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_VS_HIGH: begin
                    if (cnt_last) begin
                        state_reg <= S_VS_POST;
                        cnt_reg   <= '0;
                        vsync     <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_VS_POST: begin
                    if (cnt_last) begin
                        state_reg <= S_LINE;
                        cnt_reg   <= '0;
                        href      <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_LINE: begin
                    if (cnt_last) begin
                        state_reg <= S_HBLANK;
                        cnt_reg   <= '0;
                        href      <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_HBLANK: begin
                    if (cnt_last) begin
                        cnt_reg <= '0;
                        if (y_reg == Y_END) begin
                            state_reg  <= S_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state_reg <= S_LINE;
                            href      <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b0;
                    cnt_reg    <= '0;
                    if (continuous) begin
                        state_reg   <= S_VS_PRE;
                        pattern_reg <= pattern_sel;
                    end else begin
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= S_IDLE;
                    cnt_reg    <= '0;
                    vsync      <= 1'b0;
                    href       <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

    // Pixel position tracking and registered data byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg        <= '0;
            y_reg        <= '0;
            phase_reg    <= 1'b0;
            bar_cnt_reg  <= '0;
            bar_idx_reg  <= 3'd0;
            byte_cnt_reg <= 8'h00;
            dout         <= 8'h00;
        end else begin
            if (frame_start) begin
                x_reg        <= '0;
                y_reg        <= '0;
                phase_reg    <= 1'b0;
                bar_cnt_reg  <= '0;
                bar_idx_reg  <= 3'd0;
                byte_cnt_reg <= 8'h00;
            end
            if (emit) begin
                dout         <= pix_byte;
                phase_reg    <= ~phase_reg;
                byte_cnt_reg <= byte_cnt_reg + 8'h01;
                if (phase_reg) begin
                    if (x_reg == X_LAST) begin
                        x_reg       <= '0;
                        bar_cnt_reg <= '0;
                        bar_idx_reg <= 3'd0;
                        y_reg       <= y_reg + 1'b1;
                    end else begin
                        x_reg <= x_reg + 1'b1;
                        if (bar_cnt_reg == BAR_LAST) begin
                            bar_cnt_reg <= '0;
                            bar_idx_reg <= bar_idx_reg + 3'd1;
                        end else begin
                            bar_cnt_reg <= bar_cnt_reg + 1'b1;
                        end
                    end
                end
            end else begin
                dout <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_dvp_frame_gen.sv
// tb_dvp_frame_gen: directed test of dvp_frame_gen using three small
// parameterisations (framing/counter, colour bars, wide line).
module tb_dvp_frame_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, start_b, start_c;
    logic       continuous;
    logic [1:0] pattern_sel;

    logic       vs_a, hr_a, busy_a, done_a;
    logic [7:0] d_a;
    logic       vs_b, hr_b, busy_b, done_b;
    logic [7:0] d_b;
    logic       vs_c, hr_c, busy_c, done_c;
    logic [7:0] d_c;

    int n_checks = 0;
    int n_fail   = 0;

    logic       cap_vs   [0:1023];
    logic       cap_hr   [0:1023];
    logic       cap_busy [0:1023];
    logic       cap_done [0:1023];
    logic [7:0] cap_d    [0:1023];

    logic [15:0] bar_col [0:7];

    always #5 clk = ~clk;

    dvp_frame_gen #(.H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(3),
                    .VS_FRONT(2), .VS_PULSE(2), .VS_BACK(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .continuous(continuous),
        .pattern_sel(pattern_sel), .vsync(vs_a), .href(hr_a), .dout(d_a),
        .busy(busy_a), .frame_done(done_a));

    dvp_frame_gen #(.H_ACTIVE(16), .V_ACTIVE(2), .H_BLANK(3),
                    .VS_FRONT(2), .VS_PULSE(2), .VS_BACK(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(continuous),
        .pattern_sel(pattern_sel), .vsync(vs_b), .href(hr_b), .dout(d_b),
        .busy(busy_b), .frame_done(done_b));

    dvp_frame_gen #(.H_ACTIVE(200), .V_ACTIVE(2), .H_BLANK(4),
                    .VS_FRONT(2), .VS_PULSE(2), .VS_BACK(3)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .continuous(continuous),
        .pattern_sel(pattern_sel), .vsync(vs_c), .href(hr_c), .dout(d_c),
        .busy(busy_c), .frame_done(done_c));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic grab(input int which, input int i);
        case (which)
            0: begin
                cap_vs[i] = vs_a; cap_hr[i] = hr_a; cap_d[i] = d_a;
                cap_busy[i] = busy_a; cap_done[i] = done_a;
            end
            1: begin
                cap_vs[i] = vs_b; cap_hr[i] = hr_b; cap_d[i] = d_b;
                cap_busy[i] = busy_b; cap_done[i] = done_b;
            end
            default: begin
                cap_vs[i] = vs_c; cap_hr[i] = hr_c; cap_d[i] = d_c;
                cap_busy[i] = busy_c; cap_done[i] = done_c;
            end
        endcase
    endtask

    // Index 1 is the first cycle after the edge that samples start.
    task automatic run_frame(input int which, input int ncyc, input int pat_at,
                             input logic [1:0] pat_val, input int cont_off_at,
                             input int extra_start_at);
        @(negedge clk);
        set_start(which, 1'b1);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (i == 1) set_start(which, 1'b0);
            grab(which, i);
            if (i == pat_at) pattern_sel = pat_val;
            if (i == cont_off_at) continuous = 1'b0;
            if (i == extra_start_at) set_start(which, 1'b1);
            if (i == extra_start_at + 1) set_start(which, 1'b0);
        end
        $display("dut %0d: captured %0d cycles", which, ncyc);
    endtask

    initial begin
        int vs_first, vs_cnt, rises, hr_total, k, dirty, dones, base;
        logic [15:0] col;
        logic [7:0]  expb;

        bar_col[0] = 16'hFFFF; bar_col[1] = 16'hFFE0; bar_col[2] = 16'h07FF; bar_col[3] = 16'h07E0;
        bar_col[4] = 16'hF81F; bar_col[5] = 16'hF800; bar_col[6] = 16'h001F; bar_col[7] = 16'h0000;

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        continuous = 1'b0; pattern_sel = 2'd0;
        repeat (3) @(negedge clk);
        check_val("rst_vsync", vs_a, 0);
        check_val("rst_href", hr_a, 0);
        check_val("rst_dout", d_a, 0);
        check_val("rst_busy", busy_a, 0);
        check_val("rst_done", done_a, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---- Framing + byte counter, with an ignored start during LINE ----
        run_frame(0, 120, -1, 2'd0, -1, 10);
        check_val("A_busy_1", cap_busy[1], 1);
        check_val("A_vsync_1", cap_vs[1], 0);
        vs_first = -1; vs_cnt = 0; rises = 0; hr_total = 0; k = 0; dirty = 0; dones = 0;
        for (int i = 1; i <= 120; i++) begin
            if (cap_vs[i]) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = i;
            end
            if (cap_hr[i] && !cap_hr[i-1 < 1 ? 1 : i-1]) rises++;
            if (cap_hr[i]) begin
                hr_total++;
                expb = k[7:0];
                check_val($sformatf("A_byte%0d", k), cap_d[i], expb);
                k++;
            end else if (cap_d[i] != 8'h00) begin
                dirty++;
            end
            if (cap_done[i]) dones++;
        end
        check_val("A_vsync_first", vs_first, 3);
        check_val("A_vsync_len", vs_cnt, 2);
        check_val("A_href_first", cap_hr[8], 1);
        check_val("A_href_pre", cap_hr[7], 0);
        check_val("A_href_bursts", rises, 4);
        check_val("A_href_total", hr_total, 64);
        check_val("A_line2_gap", cap_hr[45], 0);
        check_val("A_line2_byte0", cap_d[46], 8'h20);
        check_val("A_dout_idle_nonzero", dirty, 0);
        check_val("A_done_at_84", cap_done[84], 1);
        check_val("A_done_count", dones, 1);
        check_val("A_busy_after", cap_busy[85], 0);
        check_val("A_busy_end", cap_busy[120], 0);

        // ---- Colour bars, continuous restart, pattern latching ----
        pattern_sel = 2'd1;
        continuous  = 1'b1;
        run_frame(1, 170, 20, 2'd0, 100, -1);
        for (int y = 0; y < 2; y++) begin
            base = 8 + 35 * y;
            for (int b = 0; b < 32; b++) begin
                col  = bar_col[b / 4];
                expb = (b % 2 == 1) ? col[7:0] : col[15:8];
                check_val($sformatf("B_l%0d_b%0d", y, b), cap_d[base + b], expb);
            end
        end
        check_val("B_done1", cap_done[78], 1);
        check_val("B_no_idle_busy", cap_busy[79], 1);
        check_val("B_no_idle_done", cap_done[79], 0);
        check_val("B_f2_vsync", cap_vs[81], 1);
        check_val("B_f2_vsync_pre", cap_vs[80], 0);
        check_val("B_f2_byte0", cap_d[86], 8'h00);
        check_val("B_f2_byte1", cap_d[87], 8'h01);
        check_val("B_f2_line1", cap_d[121], 8'h20);
        check_val("B_done2", cap_done[156], 1);
        check_val("B_idle_after", cap_busy[157], 0);
        dones = 0;
        for (int i = 1; i <= 170; i++) if (cap_done[i]) dones++;
        check_val("B_done_count", dones, 2);
        check_val("B_idle_end", cap_busy[170], 0);

        // ---- Wide line: counter wrap ----
        pattern_sel = 2'd0;
        run_frame(2, 820, -1, 2'd0, -1, -1);
        check_val("C_byte255", cap_d[263], 8'hFF);
        check_val("C_byte256", cap_d[264], 8'h00);
        check_val("C_byte399", cap_d[407], 8'h8F);
        check_val("C_line1_gap", cap_hr[411], 0);
        check_val("C_line1_byte0", cap_d[412], 8'h90);
        check_val("C_done", cap_done[816], 1);
        check_val("C_busy_after", cap_busy[817], 0);

        // ---- Wide line: gradient ----
        pattern_sel = 2'd2;
        run_frame(2, 820, -1, 2'd0, -1, -1);
        check_val("C_grad_x0_hi", cap_d[8], 8'h00);
        check_val("C_grad_x0_lo", cap_d[9], 8'h1F);
        check_val("C_grad_x16_hi", cap_d[40], 8'h10);
        check_val("C_grad_x16_lo", cap_d[41], 8'h1D);
        check_val("C_grad_x199_hi", cap_d[406], 8'hC0);
        check_val("C_grad_x199_lo", cap_d[407], 8'h07);

        // ---- Mid-line asynchronous reset, then recovery in pattern 3 ----
        pattern_sel = 2'd0;
        run_frame(0, 12, -1, 2'd0, -1, -1);
        check_val("R_pre_href", hr_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("R_async_vsync", vs_a, 0);
        check_val("R_async_href", hr_a, 0);
        check_val("R_async_dout", d_a, 0);
        check_val("R_async_busy", busy_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("R_idle_busy", busy_a, 0);
        check_val("R_idle_href", hr_a, 0);
        pattern_sel = 2'd3;
        run_frame(0, 90, -1, 2'd0, -1, -1);
        check_val("R_byte0", cap_d[8], 8'h00);
        check_val("R_byte1", cap_d[9], 8'h01);
        check_val("R_line3_byte0", cap_d[65], 8'h30);
        check_val("R_done", cap_done[84], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dvp_frame_gen.md
Name: dvp_frame_gen

Overview:
- Synthesizable DVP camera-side transmitter that emulates the OV7670 output timing (vsync, href, 8-bit byte bus, RGB565 sent as two bytes per pixel).
- Drives the existing OV7670 capture path on-board, so camera capture → BRAM → VGA can be checked without a sensor.
- Generates one frame per start pulse, or frames back-to-back in continuous mode.
- Offers three selectable test patterns.

Parameters:
- H_ACTIVE, 640, pixels per line; must be a multiple of 8; href stays high for 2*H_ACTIVE cycles.
- V_ACTIVE, 480, lines per frame.
- H_BLANK, 100, href-low cycles after every line, including the last line.
- VS_FRONT, 10, vsync-low cycles before the vsync pulse.
- VS_PULSE, 10, vsync-high cycles.
- VS_BACK, 100, vsync-low cycles between the vsync falling edge and the first href.

Ports:
- clk  in  1  pixel-byte clock; one byte per cycle.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- continuous  in  1  when 1, a new frame starts automatically after DONE.
- pattern_sel  in  2  0 = byte counter, 1 = colour bars, 2 = gradient, 3 = same as 0.
- vsync  out  1  frame sync, active high.
- href  out  1  line valid, active high.
- dout  out  8  DVP data byte.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-frame): state=IDLE, vsync=0, href=0, dout=0x00, busy=0, frame_done=0, all counters=0.
- FSM states: IDLE → VS_PRE (VS_FRONT cycles) → VS_HIGH (VS_PULSE) → VS_POST (VS_BACK) → LINE (2*H_ACTIVE) → HBLANK (H_BLANK) → LINE … → DONE (1 cycle).
- After the HBLANK of line V_ACTIVE-1, the FSM enters DONE.
- Exit from DONE: to VS_PRE if continuous=1 in the DONE cycle, otherwise to IDLE.
- Start handshake: start=1 in IDLE puts VS_PRE outputs (busy=1, vsync=0) on the next clock edge. start outside IDLE is ignored; there is no queueing.
- pattern_sel is latched on entry to VS_PRE and held for the whole frame. Mid-frame changes have no effect.
- Clearing continuous mid-frame lets the current frame complete, then the FSM goes to IDLE.
- vsync=1 only in VS_HIGH. href=1 only in LINE.
- Outside LINE, dout=0x00.
- frame_done=1 only in DONE.
- Byte order: within a pixel, the high byte of the RGB565 word is sent first, then the low byte.
- x = pixel index in the line (0..H_ACTIVE-1); y = line index (0..V_ACTIVE-1).
- Pattern 0 (byte counter):
  - dout = (frame byte index) mod 256, counting only LINE cycles.
  - Starts at 0x00 on the first LINE byte of each frame.
  - Wraps 0xFF→0x00; holds its value across HBLANK; restarts at 0 on the next frame.
- Pattern 1 (colour bars):
  - 8 bars, each H_ACTIVE/8 pixels wide.
  - Bar index comes from a bar-width counter, not a divider.
  - Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Same pattern on every line.
- Pattern 2 (gradient):
  - R = x[7:3], G = y[7:2], B = ~x[7:3]. All slices zero-extended from x, y counters of width clog2 of the parameter, minimum 8.
  - Word = {R,G,B}.
- Frame length from the start edge to the frame_done cycle inclusive: VS_FRONT + VS_PULSE + VS_BACK + V_ACTIVE*(2*H_ACTIVE + H_BLANK) + 1 cycles.
- Counter widths are sized from the parameters; no wrap occurs before the terminal count.

Test Plan:
- Reset, then check counter-mode framing (H_ACTIVE=8, V_ACTIVE=4, H_BLANK=3, VS_FRONT=2, VS_PULSE=2, VS_BACK=3):
  - After reset: all outputs 0.
  - start pulse → busy=1 next cycle; vsync high for exactly 2 cycles starting 2 cycles later.
  - 4 href bursts of 16 cycles, separated by 3 low cycles.
  - dout runs 0x00..0x3F, with line 2 starting at 0x20.
  - frame_done pulses once, 84 cycles after start; busy=0 after it.
- Colour bars (H_ACTIVE=16, pattern_sel=1): each line's bytes are FF,FF,FF,FF,FF,E0,FF,E0,07,FF,07,FF,… ending 00,00,00,00. Identical on every line.
- Counter wrap and wide line (H_ACTIVE=200, V_ACTIVE=2, pattern_sel=0):
  - Byte 255 of line 0 = 0xFF; byte 256 = 0x00.
  - Line 1 first byte = 0x90 (400 mod 256).
- Continuous mode and pattern latching:
  - continuous=1 → second frame's VS_PRE begins the cycle after DONE, with no IDLE cycle in between.
  - Changing pattern_sel mid-frame leaves the current frame unchanged; the change applies to the next frame.
  - Dropping continuous mid-frame → IDLE after that frame.
- Ignored start and mid-frame reset:
  - start pulses during LINE produce no extra frame.
  - rst_n low mid-line → vsync, href, dout, busy all 0 immediately (asynchronously).
  - After release, FSM stays IDLE until start; the next frame begins again at byte 0x00.
- Loopback: drive ov7670_data_12rgb444 with default parameters in pattern 1. Captured BRAM words match the RGB444 truncation of the bar colours, e.g. address 0 = 0xFFF and address 80 = 0xFF0.
